// File: rtl/mc_ctrl_ws.sv
// Multi-cycle MIPS control unit with memory wait states and a
// multi-cycle multiply/divide sequencer.
module mc_ctrl_ws #(
    parameter int MEM_WAIT  = 1,
    parameter int MD_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_rdy,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       EXTOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [1:0] GPRSel,
    output logic [1:0] WDSel,
    output logic [3:0] ALUOp,
    output logic       MDStart,
    output logic       HILOWrite,
    output logic       md_busy,
    output logic       ill_instr,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_MDU = 3'd5,
        S_ERR = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        K_ILL,
        K_J,
        K_JAL,
        K_JR,
        K_JALR,
        K_BEQ,
        K_BNE,
        K_LOAD,
        K_STORE,
        K_IALU,
        K_SHIFT,
        K_RALU,
        K_MD,
        K_MF
    } kind_t;

    localparam logic [5:0] MD_LOAD = 6'(MD_CYCLES - 1);

    localparam logic [3:0] A_ADD  = 4'b0001;
    localparam logic [3:0] A_SUB  = 4'b0010;
    localparam logic [3:0] A_AND  = 4'b0011;
    localparam logic [3:0] A_OR   = 4'b0100;
    localparam logic [3:0] A_SLT  = 4'b0101;
    localparam logic [3:0] A_SLTU = 4'b0110;
    localparam logic [3:0] A_NOR  = 4'b0111;
    localparam logic [3:0] A_SLL  = 4'b1000;
    localparam logic [3:0] A_SRL  = 4'b1001;
    localparam logic [3:0] A_LUI  = 4'b1100;
    localparam logic [3:0] A_XOR  = 4'b1101;
    localparam logic [3:0] A_SRA  = 4'b1110;

    state_t     state, nxt;
    kind_t      kind;
    logic [3:0] alu_code;
    logic       zext;
    logic [5:0] md_cnt;
    logic       mem_done;

    // Wait states are compiled out entirely when MEM_WAIT is 0.
    assign mem_done = (MEM_WAIT == 0) || mem_rdy;
    assign state_o  = state;

    always_comb begin
        kind     = K_ILL;
        alu_code = 4'b0000;
        zext     = 1'b0;
        unique case (Op)
            6'h00: begin
                unique case (Funct)
                    6'h00: begin kind = K_SHIFT; alu_code = A_SLL;  end
                    6'h02: begin kind = K_SHIFT; alu_code = A_SRL;  end
                    6'h03: begin kind = K_SHIFT; alu_code = A_SRA;  end
                    6'h04: begin kind = K_RALU;  alu_code = A_SLL;  end
                    6'h06: begin kind = K_RALU;  alu_code = A_SRL;  end
                    6'h07: begin kind = K_RALU;  alu_code = A_SRA;  end
                    6'h08: kind = K_JR;
                    6'h09: kind = K_JALR;
                    6'h10, 6'h12: kind = K_MF;
                    6'h18, 6'h19,
                    6'h1A, 6'h1B: kind = K_MD;
                    6'h20, 6'h21: begin kind = K_RALU; alu_code = A_ADD;  end
                    6'h22, 6'h23: begin kind = K_RALU; alu_code = A_SUB;  end
                    6'h24: begin kind = K_RALU; alu_code = A_AND;  end
                    6'h25: begin kind = K_RALU; alu_code = A_OR;   end
                    6'h26: begin kind = K_RALU; alu_code = A_XOR;  end
                    6'h27: begin kind = K_RALU; alu_code = A_NOR;  end
                    6'h2A: begin kind = K_RALU; alu_code = A_SLT;  end
                    6'h2B: begin kind = K_RALU; alu_code = A_SLTU; end
                    default: kind = K_ILL;
                endcase
            end
            6'h02: kind = K_J;
            6'h03: kind = K_JAL;
            6'h04: begin kind = K_BEQ; alu_code = A_SUB; end
            6'h05: begin kind = K_BNE; alu_code = A_SUB; end
            6'h08, 6'h09: begin kind = K_IALU; alu_code = A_ADD; end
            6'h0A: begin kind = K_IALU; alu_code = A_SLT;  end
            6'h0B: begin kind = K_IALU; alu_code = A_SLTU; end
            6'h0C: begin kind = K_IALU; alu_code = A_AND; zext = 1'b1; end
            6'h0D: begin kind = K_IALU; alu_code = A_OR;  zext = 1'b1; end
            6'h0E: begin kind = K_IALU; alu_code = A_XOR; end
            6'h0F: begin kind = K_IALU; alu_code = A_LUI; end
            6'h20, 6'h21, 6'h23,
            6'h24, 6'h25: begin kind = K_LOAD;  alu_code = A_ADD; end
            6'h28, 6'h29,
            6'h2B: begin kind = K_STORE; alu_code = A_ADD; end
            default: kind = K_ILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IF;
        end else begin
            state <= nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            md_cnt <= 6'd0;
        end else if (state == S_EXE && nxt == S_MDU) begin
            md_cnt <= MD_LOAD;
        end else if (state == S_MDU && md_cnt != 6'd0) begin
            md_cnt <= md_cnt - 6'd1;
        end
    end

    always_comb begin
        nxt       = state;
        PCWrite   = 1'b0;
        IorD      = 1'b0;
        MemReq    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        EXTOp     = 1'b1;
        ALUSrcA   = 2'd1;
        ALUSrcB   = 2'd0;
        PCSource  = 2'd0;
        GPRSel    = 2'd0;
        WDSel     = 2'd0;
        ALUOp     = 4'b0000;
        MDStart   = 1'b0;
        HILOWrite = 1'b0;
        md_busy   = 1'b0;
        ill_instr = 1'b0;
        unique case (state)
            S_IF: begin
                MemReq  = 1'b1;
                ALUSrcA = 2'd0;
                ALUSrcB = 2'd1;
                if (mem_done) begin
                    PCWrite = 1'b1;
                    IRWrite = 1'b1;
                    nxt     = S_ID;
                end
            end
            S_ID: begin
                unique case (kind)
                    K_J: begin
                        PCSource = 2'd2;
                        PCWrite  = 1'b1;
                        nxt      = S_IF;
                    end
                    K_JR: begin
                        PCSource = 2'd3;
                        PCWrite  = 1'b1;
                        nxt      = S_IF;
                    end
                    K_JAL: begin
                        PCSource = 2'd2;
                        PCWrite  = 1'b1;
                        RegWrite = 1'b1;
                        GPRSel   = 2'd2;
                        WDSel    = 2'd2;
                        nxt      = S_IF;
                    end
                    K_JALR: begin
                        PCSource = 2'd3;
                        PCWrite  = 1'b1;
                        RegWrite = 1'b1;
                        GPRSel   = 2'd0;
                        WDSel    = 2'd2;
                        nxt      = S_IF;
                    end
                    K_ILL: nxt = S_ERR;
                    default: begin
                        ALUSrcA = 2'd0;
                        ALUSrcB = 2'd3;
                        nxt     = S_EXE;
                    end
                endcase
            end
            S_EXE: begin
                ALUOp = alu_code;
                unique case (kind)
                    K_BEQ, K_BNE: begin
                        PCSource = 2'd1;
                        PCWrite  = (kind == K_BEQ) ? Zero : ~Zero;
                        nxt      = S_IF;
                    end
                    K_LOAD, K_STORE: begin
                        ALUSrcB = 2'd2;
                        nxt     = S_MEM;
                    end
                    K_IALU: begin
                        ALUSrcB = 2'd2;
                        EXTOp   = ~zext;
                        nxt     = S_WB;
                    end
                    K_SHIFT: begin
                        ALUSrcA = 2'd2;
                        nxt     = S_WB;
                    end
                    K_MD: begin
                        MDStart = 1'b1;
                        nxt     = S_MDU;
                    end
                    default: nxt = S_WB;
                endcase
            end
            S_MDU: begin
                md_busy = 1'b1;
                if (md_cnt == 6'd0) begin
                    HILOWrite = 1'b1;
                    nxt       = S_IF;
                end
            end
            S_MEM: begin
                IorD    = 1'b1;
                MemReq  = 1'b1;
                ALUSrcB = 2'd2;
                if (mem_done) begin
                    if (kind == K_STORE) begin
                        MemWrite = 1'b1;
                        nxt      = S_IF;
                    end else begin
                        nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                if (kind == K_LOAD) begin
                    WDSel = 2'd1;
                end else if (kind == K_MF) begin
                    WDSel = 2'd3;
                end
                if (Op != 6'h00) begin
                    GPRSel = 2'd1;
                end
                nxt = S_IF;
            end
            S_ERR: begin
                ill_instr = 1'b1;
                nxt       = S_IF;
            end
            default: nxt = S_IF;
        endcase
    end

endmodule

// File: doc/mc_ctrl_ws.md
MC_CTRL_WS -- requirements
Module: mc_ctrl_ws

Interface
REQ-001 Parameter MEM_WAIT, default 1; 1 = memory accesses hold until mem_rdy, 0 = mem_rdy ignored and every access completes in one cycle.
REQ-002 Parameter MD_CYCLES, default 32, legal 1..63; number of cycles the multiply/divide unit is held busy.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 Op / Funct  in  6 / 6  opcode and funct fields from IR.
REQ-006 Zero  in  1  ALU zero flag; mem_rdy  in  1  memory access complete this cycle.
REQ-007 PCWrite, IorD, MemReq, MemWrite, IRWrite, RegWrite, EXTOp  out  1 each  datapath strobes; EXTOp 1 = sign-extend, 0 = zero-extend.
REQ-008 ALUSrcA, ALUSrcB, PCSource, GPRSel, WDSel  out  2 each  mux selects.
- ALUSrcA: 0 PC, 1 A, 2 shamt.
- ALUSrcB: 0 B, 1 const 4, 2 Imm32, 3 branch offset.
- PCSource: 0 ALU, 1 ALUOut, 2 jump, 3 register.
- GPRSel: 0 rd, 1 rt, 2 $31.
- WDSel: 0 ALU, 1 MEM, 2 PC, 3 HI/LO.
REQ-009 ALUOp  out  4  ALU operation code.
REQ-010 MDStart, HILOWrite, md_busy, ill_instr  out  1 each  MDU start pulse, HI/LO load, MDU busy, illegal-opcode pulse.
REQ-011 state_o  out  3  current state, for debug.

Function
REQ-012 States SHALL be: IF=0, ID=1, EXE=2, MEM=3, WB=4, MDU=5, ERR=6.
REQ-013 Every output SHALL default to 0 in every state, except ALUSrcA=1 and EXTOp=1; each state overrides only what it lists.
REQ-014 IF SHALL assert MemReq with ALUSrcA=0 and ALUSrcB=1.
- PCWrite and IRWrite SHALL assert only in the cycle mem_rdy=1, or every IF cycle when MEM_WAIT=0.
- On completion IF goes to ID; otherwise it stays in IF.
REQ-015 ID, j: PCSource=2, PCWrite=1, next state IF.
REQ-016 ID, jr: PCSource=3, PCWrite=1, next state IF.
REQ-017 ID, jal: PCSource=2, PCWrite=1, RegWrite=1, GPRSel=2, WDSel=2, next state IF.
REQ-018 ID, jalr: PCSource=3, PCWrite=1, RegWrite=1, GPRSel=0, WDSel=2, next state IF.
REQ-019 ID, unrecognised Op/Funct: next state ERR.
REQ-020 ID, all other instructions: ALUSrcA=0, ALUSrcB=3, next state EXE.
REQ-021 ALUOp SHALL be driven only in EXE, with these codes:
- 0001 add/addu/addi/loads/stores; 0010 sub/subu/beq/bne; 0011 and/andi; 0100 or/ori.
- 0101 slt/slti; 0110 sltu; 0111 nor; 1000 sll/sllv; 1001 srl/srlv.
- 1100 lui; 1101 xor; 1110 sra/srav.
REQ-022 EXE, beq/bne: PCSource=1, PCWrite=(beq&Zero)|(bne&~Zero), next state IF.
REQ-023 EXE, loads/stores: ALUSrcB=2, next state MEM.
REQ-024 EXE, other I-format: ALUSrcB=2, EXTOp=0 for andi/ori, next state WB.
REQ-025 EXE, sll/srl/sra: ALUSrcA=2, next state WB; other R-format: next state WB.
REQ-026 EXE, mult/multu/div/divu: MDStart=1 for exactly one cycle, next state MDU.
REQ-027 EXE, mfhi/mflo: next state WB.
REQ-028 MDU SHALL hold md_busy=1, load a counter with MD_CYCLES-1 on entry and decrement it each cycle.
- At count 0: HILOWrite=1 for one cycle, next state IF.
- MD_CYCLES=1: exactly one MDU cycle.
REQ-029 MEM SHALL assert IorD=1 and MemReq=1, hold all selects stable and stay in MEM until mem_rdy=1.
- Stores: MemWrite=1 only in the completing cycle, then IF.
- Loads: no MemWrite, then WB.
REQ-030 WB SHALL assert RegWrite=1 for one cycle, then IF.
- WDSel=1 for loads, 3 for mfhi/mflo, 0 otherwise.
- GPRSel=1 for I-format, 0 otherwise.
REQ-031 ERR SHALL pulse ill_instr=1 for one cycle with no register or memory write, then IF.
REQ-032 Op/Funct SHALL be treated as stable from ID until the instruction retires; mem_rdy sampled outside IF/MEM SHALL be ignored.

Reset
REQ-033 rst=1 at a clock edge SHALL force state IF, MDU counter 0 and md_busy 0, and abort any pending wait or MDU operation; outputs follow the IF decode the next cycle.
REQ-034 rst SHALL take priority over every transition, including an MDU completion or mem_rdy in the same cycle.

Verification
REQ-035 add, MEM_WAIT=0 -> IF,ID,EXE,WB; ALUOp=0001 in EXE; RegWrite=1 in the 4th cycle only.
REQ-036 lw with mem_rdy low 3 cycles in MEM -> MEM held 4 cycles, IorD=1 throughout, then WB with WDSel=1 and GPRSel=1.
REQ-037 sw, MEM_WAIT=1, mem_rdy high on the 2nd MEM cycle -> MemWrite=1 on exactly that cycle, then IF.
REQ-038 mult with MD_CYCLES=4 -> MDStart one cycle in EXE, md_busy 4 cycles, HILOWrite on the last, then IF; mflo then writes with WDSel=3.
REQ-039 bne with Zero=1 -> PCWrite=0; with Zero=0 -> PCWrite=1, PCSource=1.
REQ-040 rst asserted on the 2nd MDU cycle -> next cycle state_o=0, md_busy=0, no HILOWrite; Op=0x3F -> ERR, ill_instr one cycle, no RegWrite.
